eth_rxcounters: RTL and testbench
=================================

// Module: eth_rxcounters
// PURPOSE
//  Receive-side counter bank feeding the RX state machine. Produces the
//  field/byte counters and flags that time every state transition:
//  - preamble: nibble count to 13
//  - SFD: count to 1
//  - DA/SA: 6 bytes
//  - Length: 2 bytes
//  - Data: byte count checked against max frame
//  - inter-frame gap: count to 24
//  Sits beside the RX state machine: consumes its one-hot state outputs, returns counts.
// PARAMETERS
//  IFG_CNT_MAX   24   idle cycles (nibbles) for a legal inter-frame gap; counter saturates here
//  BYTECNT_W     16   width of ByteCnt and MaxFL
// PORTS
//  MRxClk           in   1          receive clock
//  Reset            in   1          async reset, active-high
//  MRxDV            in   1          MII receive data valid
//  StateIdle        in   1          RX FSM in IDLE
//  StateDrop        in   1          RX FSM in DROP
//  StatePreamble    in   1          RX FSM in PREAMBLE
//  StateSFD         in   1          RX FSM in SFD
//  StateDA          in   1          RX FSM in DA
//  StateSA          in   1          RX FSM in SA
//  StateLength      in   1          RX FSM in LENGTH
//  StateData        in   2          {DATA1,DATA0} one-hot
//  r_IFG            in   1          ignore-IFG config bit; forces IFGCounterEq24=1
//  MaxFL            in   BYTECNT_W  max data bytes (e.g. 1500)
//  ByteCnt          out  BYTECNT_W  field counter (nibbles in PRE/SFD, bytes elsewhere)
//  Rx_NibCnt        out  1          nibble phase within byte in DA/SA/LENGTH (0=low,1=high)
//  ByteCntEq0       out  1          ByteCnt==0
//  ByteCntGreat2    out  1          ByteCnt>2
//  ByteCntMaxFrame  out  1          ByteCnt==MaxFL while in data states
//  IFGCounterEq24   out  1          IFG counter==IFG_CNT_MAX, or r_IFG
// BEHAVIOUR
//  Reset values: ByteCnt=0, Rx_NibCnt=0, IFG counter=0, so ByteCntEq0=1 and all other flags 0
//  (IFGCounterEq24=r_IFG). Registers update on posedge MRxClk; flags are combinational
//  decodes of registers (0-cycle latency from count).
//  Counting advances only when MRxDV=1. MRxDV=0 holds ByteCnt/Rx_NibCnt, except in
//  IDLE/DROP, where both clear.
//  Terminal counts self-wrap to 0 on the same edge on which the FSM leaves the field, so
//  the new state always starts at ByteCnt=0, Rx_NibCnt=0:
//   PREAMBLE: ByteCnt++ per cycle; at 13 -> 0.
//   SFD:      ByteCnt++ per cycle; at 1 -> 0.
//   DA, SA:   {ByteCnt,Rx_NibCnt} increments as one nibble counter;
//             at ByteCnt=5 & Rx_NibCnt=1 -> both 0.
//   LENGTH:   same scheme; at ByteCnt=1 & Rx_NibCnt=1 -> both 0.
//   DATA0:    hold.
//   DATA1:    ByteCnt++ (one byte per DATA0/DATA1 pair). Saturates at MaxFL, never wraps.
//             Rx_NibCnt=0.
//   IDLE, DROP, no state bit: ByteCnt=0, Rx_NibCnt=0.
//  ByteCntMaxFrame is asserted only when StateData!=0 and ByteCnt==MaxFL.
//  MaxFL=0 asserts it on the first DATA0 cycle.
//  IFG counter (5 bit):
//   - clears when StateSFD or any StateData bit is set;
//   - otherwise in IDLE, DROP or PREAMBLE it increments each cycle and saturates at IFG_CNT_MAX;
//   - otherwise it holds.
//  Simultaneous state bits (illegal): the priority order is IDLE/DROP, then SFD, then
//  DATA, then the rest.
//  Reset asserted mid-frame: all counters return to reset values immediately
//  (asynchronous) and counting resumes on the first edge after deassertion.
// STRUCTURE
//  eth_rx_pkg holds the constants: PRE_LAST=13, SFD_LAST=1, ADDR_LAST_BYTE=5,
//  LEN_LAST_BYTE=1, IFG_CNT_MAX=24. The RX FSM shares the same constants so that
//  terminal counts cannot diverge.
//  One sub-module, eth_rx_ifgcnt: the saturating IFG counter with clear/enable and Eq flag.
//  ByteCnt/Rx_NibCnt logic stays in the top module.
// TESTING
//  1. Reset: assert Reset 3 cycles -> ByteCnt=0, Rx_NibCnt=0, ByteCntEq0=1,
//     IFGCounterEq24=0. Then drive StateIdle, MRxDV=0 for 30 cycles ->
//     IFGCounterEq24 rises on cycle 24 and holds.
//  2. Preamble/SFD: StatePreamble+MRxDV for 14 cycles -> ByteCnt 0..13, then 0.
//     StateSFD for 2 cycles -> 0,1,0. IFG counter clears on the first SFD cycle.
//  3. DA/SA/LENGTH: StateDA+MRxDV for 12 cycles -> (ByteCnt,Rx_NibCnt) steps
//     (0,0)..(5,1), then (0,0). Repeat for SA. LENGTH for 4 cycles -> ends (1,1), then (0,0).
//     Drop MRxDV for 2 cycles mid-DA -> counts hold.
//  4. Data/max frame: MaxFL=4, alternate DATA0/DATA1 with MRxDV=1 ->
//     ByteCnt 0,0,1,1,2,2,3,3,4. ByteCntMaxFrame=1 at ByteCnt=4 in DATA0; ByteCnt stays 4.
//     ByteCntGreat2 first asserts at ByteCnt=3.
//  5. r_IFG=1 with the IFG counter at 0 -> IFGCounterEq24=1 immediately.
//  6. Reset mid-frame at DA byte 3 -> outputs return to reset values the same cycle.
//     StateIdle afterwards -> IFG counts from 0.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg
//   Constants shared by the RX counter bank and the RX state machine, so that
//   terminal counts cannot diverge between the two. It also holds the decoded
//   "field" selector used by the counter bank.
package eth_rx_pkg;

   localparam int PRE_LAST       = 13;  // last preamble nibble count
   localparam int SFD_LAST       = 1;   // last SFD nibble count
   localparam int ADDR_LAST_BYTE = 5;   // DA/SA are 6 bytes
   localparam int LEN_LAST_BYTE  = 1;   // length/type is 2 bytes
   localparam int IFG_CNT_MAX    = 24;  // nibbles of legal inter-frame gap
   localparam int IFG_CNT_W      = 5;

   // Field currently being counted, after priority resolution of the
   // one-hot state inputs.
   typedef enum logic [2:0] {
      FLD_CLR,
      FLD_PRE,
      FLD_SFD,
      FLD_ADDR,
      FLD_LEN,
      FLD_DATA0,
      FLD_DATA1
   } field_e;

endpackage

// File: rtl/eth_rx_ifgcnt.sv
// eth_rx_ifgcnt
//   Saturating inter-frame-gap counter.
//   Ports:
//     MRxClk, Reset : receive clock, asynchronous active-high reset
//     Clear         : synchronous clear (wins over Incr)
//     Incr          : count up by one, saturating at CNT_MAX
//     CountEqMax    : counter has reached CNT_MAX
module eth_rx_ifgcnt
   import eth_rx_pkg::*;
#(
   parameter int CNT_MAX = IFG_CNT_MAX,
   parameter int CNT_W   = IFG_CNT_W
) (
   input  logic MRxClk,
   input  logic Reset,
   input  logic Clear,
   input  logic Incr,
   output logic CountEqMax
);

   logic [CNT_W-1:0] ifgCount;

   assign CountEqMax = (ifgCount == CNT_W'(CNT_MAX));

   always_ff @(posedge MRxClk or posedge Reset) begin
      if (Reset)
         ifgCount <= '0;
      else if (Clear)
         ifgCount <= '0;
      else if (Incr && !CountEqMax)
         ifgCount <= ifgCount + 1'b1;
   end

endmodule

// File: rtl/eth_rxcounters.sv
// eth_rxcounters
//   Receive-side counter bank for the RX state machine. It keeps the field
//   counter (nibbles in PREAMBLE/SFD, bytes elsewhere), the nibble phase inside
//   DA/SA/LENGTH bytes and the inter-frame-gap counter, and it decodes the flags
//   the FSM uses to time its transitions.
//   Ports:
//     MRxClk, Reset      : receive clock, asynchronous active-high reset
//     MRxDV              : MII data valid; counting only advances while high
//     State*             : one-hot RX FSM state (StateData = {DATA1,DATA0})
//     r_IFG              : ignore-IFG config, forces IFGCounterEq24
//     MaxFL              : maximum number of data bytes
//     ByteCnt, Rx_NibCnt : field counter and nibble phase
//     ByteCntEq0/Great2/MaxFrame, IFGCounterEq24 : decoded flags
module eth_rxcounters
   import eth_rx_pkg::*;
#(
   parameter int IFG_MAX   = IFG_CNT_MAX,
   parameter int BYTECNT_W = 16
) (
   input  logic                 MRxClk,
   input  logic                 Reset,
   input  logic                 MRxDV,
   input  logic                 StateIdle,
   input  logic                 StateDrop,
   input  logic                 StatePreamble,
   input  logic                 StateSFD,
   input  logic                 StateDA,
   input  logic                 StateSA,
   input  logic                 StateLength,
   input  logic [1:0]           StateData,
   input  logic                 r_IFG,
   input  logic [BYTECNT_W-1:0] MaxFL,
   output logic [BYTECNT_W-1:0] ByteCnt,
   output logic                 Rx_NibCnt,
   output logic                 ByteCntEq0,
   output logic                 ByteCntGreat2,
   output logic                 ByteCntMaxFrame,
   output logic                 IFGCounterEq24
);

   field_e               field;
   logic [BYTECNT_W-1:0] byteCntNxt;
   logic                 nibCntNxt;
   logic                 idleOrDrop;
   logic                 ifgEq;

   assign idleOrDrop = StateIdle | StateDrop;

   // Priority when the FSM is broken and several bits are set:
   // IDLE/DROP, then SFD, then DATA, then the remaining fields.
   always_comb begin
      field = FLD_CLR;
      if (idleOrDrop)         field = FLD_CLR;
      else if (StateSFD)      field = FLD_SFD;
      else if (StateData[1])  field = FLD_DATA1;
      else if (StateData[0])  field = FLD_DATA0;
      else if (StatePreamble) field = FLD_PRE;
      else if (StateDA | StateSA) field = FLD_ADDR;
      else if (StateLength)   field = FLD_LEN;
   end

   // Terminal counts wrap to zero on the edge where the FSM leaves the field,
   // so every field starts at ByteCnt=0, Rx_NibCnt=0.
   always_comb begin
      byteCntNxt = ByteCnt;
      nibCntNxt  = Rx_NibCnt;
      if (field == FLD_CLR) begin
         byteCntNxt = '0;
         nibCntNxt  = 1'b0;
      end else if (MRxDV) begin
         nibCntNxt = 1'b0;
         case (field)
            FLD_PRE:
               byteCntNxt = (ByteCnt == BYTECNT_W'(PRE_LAST)) ? '0 : ByteCnt + 1'b1;
            FLD_SFD:
               byteCntNxt = (ByteCnt == BYTECNT_W'(SFD_LAST)) ? '0 : ByteCnt + 1'b1;
            FLD_ADDR, FLD_LEN: begin
               // {ByteCnt,Rx_NibCnt} behaves as a single nibble counter
               if (Rx_NibCnt && ByteCnt == BYTECNT_W'((field == FLD_ADDR) ?
                                                      ADDR_LAST_BYTE : LEN_LAST_BYTE))
                  byteCntNxt = '0;
               else begin
                  nibCntNxt = ~Rx_NibCnt;
                  if (Rx_NibCnt)
                     byteCntNxt = ByteCnt + 1'b1;
               end
            end
            FLD_DATA1:
               // one byte per DATA0/DATA1 pair; saturates, never wraps
               if (ByteCnt < MaxFL)
                  byteCntNxt = ByteCnt + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge MRxClk or posedge Reset) begin
      if (Reset) begin
         ByteCnt   <= '0;
         Rx_NibCnt <= 1'b0;
      end else begin
         ByteCnt   <= byteCntNxt;
         Rx_NibCnt <= nibCntNxt;
      end
   end

   assign ByteCntEq0      = (ByteCnt == '0);
   assign ByteCntGreat2   = (ByteCnt > BYTECNT_W'(2));
   assign ByteCntMaxFrame = (|StateData) && (ByteCnt == MaxFL);

   // The gap restarts once a frame is committed (SFD/DATA) and accumulates in
   // IDLE, DROP and PREAMBLE; IDLE/DROP outrank the clear.
   eth_rx_ifgcnt #(
      .CNT_MAX (IFG_MAX),
      .CNT_W   (IFG_CNT_W)
   ) u_ifgcnt (
      .MRxClk     (MRxClk),
      .Reset      (Reset),
      .Clear      (~idleOrDrop & (StateSFD | (|StateData))),
      .Incr       (idleOrDrop | StatePreamble),
      .CountEqMax (ifgEq)
   );

   assign IFGCounterEq24 = ifgEq | r_IFG;

endmodule

// File: tb/tb_eth_rxcounters.sv
module tb_eth_rxcounters;

   localparam int S_NONE = 0, S_IDLE = 1, S_DROP = 2, S_PRE = 3, S_SFD = 4,
                  S_DA = 5, S_SA = 6, S_LEN = 7, S_D0 = 8, S_D1 = 9;

   logic        MRxClk = 1'b0;
   logic        Reset;
   logic        MRxDV;
   logic        StateIdle, StateDrop, StatePreamble, StateSFD;
   logic        StateDA, StateSA, StateLength;
   logic [1:0]  StateData;
   logic        r_IFG;
   logic [15:0] MaxFL;
   logic [15:0] ByteCnt;
   logic        Rx_NibCnt, ByteCntEq0, ByteCntGreat2, ByteCntMaxFrame, IFGCounterEq24;

   eth_rxcounters dut (
      .MRxClk(MRxClk), .Reset(Reset), .MRxDV(MRxDV),
      .StateIdle(StateIdle), .StateDrop(StateDrop), .StatePreamble(StatePreamble),
      .StateSFD(StateSFD), .StateDA(StateDA), .StateSA(StateSA),
      .StateLength(StateLength), .StateData(StateData), .r_IFG(r_IFG), .MaxFL(MaxFL),
      .ByteCnt(ByteCnt), .Rx_NibCnt(Rx_NibCnt), .ByteCntEq0(ByteCntEq0),
      .ByteCntGreat2(ByteCntGreat2), .ByteCntMaxFrame(ByteCntMaxFrame),
      .IFGCounterEq24(IFGCounterEq24)
   );

   always #5 MRxClk = ~MRxClk;

   int nChk = 0, nPass = 0;
   int curSt = S_NONE;
   // reference model: field count, nibble phase, gap length
   int mB = 0, mN = 0, mI = 0;

   typedef struct {
      int st; bit dv; int eb; int en; int em;
   } vec_t;
   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      nChk++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic setIn(input int st, input bit dv);
      curSt = st;
      MRxDV = dv;
      StateIdle = (st == S_IDLE); StateDrop = (st == S_DROP);
      StatePreamble = (st == S_PRE); StateSFD = (st == S_SFD);
      StateDA = (st == S_DA); StateSA = (st == S_SA); StateLength = (st == S_LEN);
      StateData = {st == S_D1, st == S_D0};
   endtask

   task automatic chkAll(input string tag);
      bit inData;
      inData = (curSt == S_D0) || (curSt == S_D1);
      chk({tag, ".ByteCnt"}, ByteCnt, mB);
      chk({tag, ".Rx_NibCnt"}, Rx_NibCnt, mN);
      chk({tag, ".ByteCntEq0"}, ByteCntEq0, (mB == 0));
      chk({tag, ".ByteCntGreat2"}, ByteCntGreat2, (mB > 2));
      chk({tag, ".ByteCntMaxFrame"}, ByteCntMaxFrame, (inData && mB == int'(MaxFL)));
      chk({tag, ".IFGCounterEq24"}, IFGCounterEq24, ((mI == 24) || r_IFG));
   endtask

   // One clock: apply inputs, advance the model by the field rules, check.
   task automatic cyc(input int st, input bit dv, input string tag);
      int k, nNib;
      setIn(st, dv);
      if (st == S_NONE || st == S_IDLE || st == S_DROP) begin
         mB = 0; mN = 0;
      end else if (dv) begin
         case (st)
            S_PRE: mB = (mB == 13) ? 0 : mB + 1;
            S_SFD: mB = (mB == 1) ? 0 : mB + 1;
            S_DA, S_SA, S_LEN: begin
               nNib = (st == S_LEN) ? 4 : 12;   // nibbles in the field
               k = 2 * mB + mN;
               k = (k == nNib - 1) ? 0 : k + 1;
               mB = k / 2; mN = k % 2;
            end
            S_D1: if (mB < int'(MaxFL)) mB = mB + 1;
            default: ;
         endcase
         if (st != S_DA && st != S_SA && st != S_LEN) mN = 0;
      end
      if (st == S_IDLE || st == S_DROP || st == S_PRE) mI = (mI < 24) ? mI + 1 : 24;
      else if (st == S_SFD || st == S_D0 || st == S_D1) mI = 0;
      @(posedge MRxClk);
      #1;
      chkAll(tag);
      @(negedge MRxClk);
   endtask

   initial begin
      Reset = 1'b1; r_IFG = 1'b0; MaxFL = 16'd4;
      setIn(S_NONE, 1'b0);
      // 1. reset
      repeat (3) @(posedge MRxClk);
      @(negedge MRxClk);
      chk("rst.ByteCnt", ByteCnt, 0);
      chk("rst.Rx_NibCnt", Rx_NibCnt, 0);
      chk("rst.ByteCntEq0", ByteCntEq0, 1);
      chk("rst.IFGCounterEq24", IFGCounterEq24, 0);
      chk("rst.ByteCntGreat2", ByteCntGreat2, 0);
      Reset = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         cyc(S_IDLE, 1'b0, "ifgIdle");
         chk("ifgIdle.rise", IFGCounterEq24, (i >= 24));
      end

      // 2-4. directed field sequences, expected values written from the field lengths
      for (int i = 0; i < 14; i++) vq.push_back('{S_PRE, 1'b1, (i + 1) % 14, 0, 0});
      vq.push_back('{S_SFD, 1'b1, 1, 0, 0});
      vq.push_back('{S_SFD, 1'b1, 0, 0, 0});
      for (int i = 0; i < 12; i++) vq.push_back('{S_DA, 1'b1, ((i + 1) % 12) / 2, (i + 1) % 2, 0});
      for (int i = 0; i < 12; i++) vq.push_back('{S_SA, 1'b1, ((i + 1) % 12) / 2, (i + 1) % 2, 0});
      for (int i = 0; i < 4; i++)  vq.push_back('{S_LEN, 1'b1, ((i + 1) % 4) / 2, (i + 1) % 2, 0});
      vq.push_back('{S_DA, 1'b1, 0, 1, 0});
      vq.push_back('{S_DA, 1'b1, 1, 0, 0});
      vq.push_back('{S_DA, 1'b1, 1, 1, 0});
      vq.push_back('{S_DA, 1'b0, 1, 1, 0});
      vq.push_back('{S_DA, 1'b0, 1, 1, 0});
      vq.push_back('{S_DA, 1'b1, 2, 0, 0});
      vq.push_back('{S_IDLE, 1'b0, 0, 0, 0});
      for (int i = 0; i < 11; i++) begin
         int b;
         b = ((i + 1) / 2 > 4) ? 4 : (i + 1) / 2;
         vq.push_back('{(i % 2 == 0) ? S_D0 : S_D1, 1'b1, b, 0, (b == 4)});
      end
      foreach (vq[i]) begin
         cyc(vq[i].st, vq[i].dv, "tbl");
         chk("tbl.ByteCnt", ByteCnt, vq[i].eb);
         chk("tbl.Rx_NibCnt", Rx_NibCnt, vq[i].en);
         chk("tbl.MaxFrame", ByteCntMaxFrame, vq[i].em);
      end
      chk("ifgAfterData", IFGCounterEq24, 0);

      // 5. r_IFG forces the flag with the gap counter at 0
      r_IFG = 1'b1; #1;
      chk("rIFG.force", IFGCounterEq24, 1);
      r_IFG = 1'b0; #1;
      chk("rIFG.release", IFGCounterEq24, 0);

      // MaxFL=0: flag on the first DATA0 cycle
      cyc(S_IDLE, 1'b0, "mfl0");
      MaxFL = 16'd0;
      setIn(S_D0, 1'b1); #1;
      chk("mfl0.first", ByteCntMaxFrame, 1);
      cyc(S_D0, 1'b1, "mfl0");
      cyc(S_D1, 1'b1, "mfl0");
      chk("mfl0.sat", ByteCnt, 0);
      MaxFL = 16'd1500;

      // 6. asynchronous reset at DA byte 3
      cyc(S_IDLE, 1'b0, "mid");
      for (int i = 0; i < 7; i++) cyc(S_DA, 1'b1, "mid");
      chk("mid.pre", ByteCnt, 3);
      #2 Reset = 1'b1; #1;
      chk("mid.ByteCnt", ByteCnt, 0);
      chk("mid.Rx_NibCnt", Rx_NibCnt, 0);
      chk("mid.ByteCntEq0", ByteCntEq0, 1);
      mB = 0; mN = 0; mI = 0;
      @(negedge MRxClk);
      Reset = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         cyc(S_IDLE, 1'b0, "midIfg");
         chk("midIfg.rise", IFGCounterEq24, (i >= 24));
      end

      // random state runs against the model
      for (int s = 0; s < 500; s++) begin
         int st, len;
         st = $urandom_range(0, 9);
         len = $urandom_range(1, 16);
         if ($urandom_range(0, 7) == 0) MaxFL = 16'($urandom_range(0, 10));
         r_IFG = ($urandom_range(0, 9) == 0);
         for (int c = 0; c < len; c++) cyc(st, ($urandom_range(0, 3) != 0), "rnd");
      end

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

endmodule
